// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: stores {parity_err, framing_err, data} with a registered read port.
// Optional high-water-mark output enabled by defining UART_RX_FIFO_HWM_EN.
module uart_rx_fifo #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [7:0]        i_wr_data,
  input  logic              i_wr_framing_error,
  input  logic              i_wr_parity_error,
  output logic              o_full,
  output logic              o_almost_full,
  input  logic              i_rd_en,
  output logic [7:0]        o_rd_data,
  output logic              o_rd_framing_error,
  output logic              o_rd_parity_error,
  output logic              o_rd_valid,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic              o_underflow,
  input  logic              i_clr_status
`ifdef UART_RX_FIFO_HWM_EN
  ,
  output logic [ADDR_W:0]   o_hwm
`endif
);

  localparam int DATA_W  = 8;
  localparam int ENTRY_W = DATA_W + 2;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_THRESH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W:0]    count;
  logic               full;
  logic               empty;
  logic               wr_ok;
  logic               rd_ok;
  logic               wr_drop;
  logic               rd_drop;
  logic [ENTRY_W-1:0] rd_word_p1;
  logic               vld_p1;
  logic               ovf;
  logic               unf;

  // Occupancy step clamped to 0..DEPTH regardless of the request pair.
  function automatic logic [ADDR_W:0] sat_count(input logic [ADDR_W:0] c,
                                                input logic inc, input logic dec);
    logic [ADDR_W:0] r;
    r = c;
    if (inc && !dec && c != DEPTH_C) r = c + ONE_C;
    else if (dec && !inc && c != '0) r = c - ONE_C;
    return r;
  endfunction

  // Flags come only from the count register, so o_full has no path from i_wr_en.
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign wr_ok   = i_wr_en && !full;
  assign rd_ok   = i_rd_en && !empty;
  assign wr_drop = i_wr_en && full;
  assign rd_drop = i_rd_en && empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= sat_count(count, wr_ok, rd_ok);
      if (wr_drop)           ovf <= 1'b1;
      else if (i_clr_status) ovf <= 1'b0;
      if (rd_drop)           unf <= 1'b1;
      else if (i_clr_status) unf <= 1'b0;
    end
  end

  // Storage array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= {i_wr_parity_error, i_wr_framing_error, i_wr_data};
  end

  // Read stage p1: head entry registered alongside its valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_word_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_ok;
      if (rd_ok) rd_word_p1 <= mem[rd_ptr];
    end
  end

  assign o_rd_data          = rd_word_p1[DATA_W-1:0];
  assign o_rd_framing_error = rd_word_p1[DATA_W];
  assign o_rd_parity_error  = rd_word_p1[DATA_W+1];
  assign o_rd_valid         = vld_p1;
  assign o_full             = full;
  assign o_empty            = empty;
  assign o_almost_full      = (count >= AFULL_C);
  assign o_count            = count;
  assign o_overflow         = ovf;
  assign o_underflow        = unf;

`ifdef UART_RX_FIFO_HWM_EN
  logic [ADDR_W:0] hwm;

  // Tracks the registered count, so it trails count by one cycle.
  always_ff @(posedge clk) begin
    if (rst)               hwm <= '0;
    else if (i_clr_status) hwm <= count;
    else if (count > hwm)  hwm <= count;
  end

  assign o_hwm = hwm;
`endif

endmodule
